processor_ctrl: RTL and testbench
=================================

// Module: processor_ctrl
// PURPOSE
//  Main control/decode unit of the ARM-LP datapath. Classifies a 32-bit instruction
//  word into an operation type and drives the datapath control flags: register
//  write, memory read/write, ALU source select, ALU control code, branch flags.
//  Outputs are registered: one clock of latency from instruction to flags.
// PARAMETERS
//  none
// PORTS
//  clk                      in   1   system clock; all state updates on posedge
//  reset                    in   1   synchronous, active-high; clears all outputs
//  instruction              in   32  instruction word to decode
//  regWriteFlag             out  1   write ALU/memory result to register file
//  opType                   out  3   instruction class (encoding below)
//  memWriteFlag             out  1   data-memory write enable
//  memReadFlag              out  1   data-memory read enable
//  aluControlCode           out  4   ALU operation select
//  branchFlag               out  1   conditional branch (CBZ)
//  unconditionalBranchFlag  out  1   unconditional branch (B)
//  aluSRC                   out  1   0 = ALU B operand from register, 1 = from immediate
// BEHAVIOUR
//  - One clock, clk; reset synchronous active-high. Reset forces every output to 0.
//  - At each posedge (reset low), outputs take the decode of the current instruction.
//    Latency is 1 cycle; the decode logic itself is purely combinational.
//  - opType: 0 NONE, 1 R, 2 I, 3 LOAD, 4 STORE, 5 B, 6 CB, 7 MOV.
//  - Class decode, priority order (first match wins), b = instruction bit:
//      b26 & b29 -> CB;  b26 -> B;  b27 & b28 -> STORE;  b27 -> R;
//      b28 & b22 -> LOAD;  b28 & b23 -> MOV;  b28 -> I;  otherwise -> NONE.
//  - Function field f = instruction[31:29] selects the ALU code for R and I:
//      000 ADD=2, 001 SUB=10, 010 AND=6, 011 OR=4, 100 XOR=9, 101 NOR=5,
//      110 NAND=12, 111 MOV=13.
//  - Flags per class (regW,memW,memR,br,ubr,aluSRC / aluControlCode):
//      R     1,0,0,0,0,0 / f-code      I     1,0,0,0,0,1 / f-code
//      LOAD  1,0,1,0,0,1 / 2           STORE 0,1,0,0,0,1 / 2
//      CB    0,0,0,1,0,0 / 7 (pass B)  B     0,0,0,0,1,0 / 0
//      MOV   1,0,0,0,0,1 / 13          NONE  all 0 / 0
//  - memWriteFlag and memReadFlag are never both 1; branchFlag and
//    unconditionalBranchFlag are never both 1.
//  - An X/Z instruction (e.g., before it is first driven) is not required to decode
//    cleanly. Once reset is applied, outputs are 0 until the first valid decode.
//  - Reset asserted in the same cycle as any instruction wins; outputs are 0.
// TESTING
//  - reset=1 for 2 cycles -> all outputs 0; release reset with instruction=0 -> still 0.
//  - 0x10400000 (LOAD) -> opType=3, regW=1, memR=1, memW=0, alu=2, aluSRC=1, br=ubr=0.
//  - 0x24000000 (CB) -> opType=6, br=1, alu=7, regW=0; 0x04000000 (B) -> opType=5,
//    ubr=1, br=0, alu=0.
//  - 0x08000000 (R ADD) -> opType=1, regW=1, alu=2, aluSRC=0; 0x28000000 -> alu=10;
//    0xE8000000 -> alu=13.
//  - 0x18000000 (STORE) -> opType=4, memW=1, memR=0, regW=0, alu=2, aluSRC=1;
//    0x10000000 (I) -> opType=2, regW=1, aluSRC=1, alu=2.
//  - 0x10800000 (MOV) -> opType=7, regW=1, alu=13, aluSRC=1. Check each response
//    appears exactly 1 cycle after the instruction changes. Assert reset mid-stream
//    -> outputs 0 on the next edge.

Source files
------------

// File: rtl/processor_ctrl_if.sv
// ---------------------------------------------------------------------------
// processor_ctrl_if
//  Bundle between the instruction source and the control/decode unit.
//  Signals:
//    instruction              32  instruction word presented for decode
//    regWriteFlag             1   register-file write enable
//    opType                   3   instruction class
//    memWriteFlag             1   data-memory write enable
//    memReadFlag              1   data-memory read enable
//    aluControlCode           4   ALU operation select
//    branchFlag               1   conditional branch (CBZ)
//    unconditionalBranchFlag  1   unconditional branch (B)
//    aluSRC                   1   ALU B operand: 0 register, 1 immediate
//  Modports:
//    master  drives instruction, observes the control flags
//    slave   the decoder: receives instruction, drives the control flags
// ---------------------------------------------------------------------------
interface processor_ctrl_if;
   logic [31:0] instruction;
   logic        regWriteFlag;
   logic [2:0]  opType;
   logic        memWriteFlag;
   logic        memReadFlag;
   logic [3:0]  aluControlCode;
   logic        branchFlag;
   logic        unconditionalBranchFlag;
   logic        aluSRC;

   modport master (
      output instruction,
      input  regWriteFlag, opType, memWriteFlag, memReadFlag,
      input  aluControlCode, branchFlag, unconditionalBranchFlag, aluSRC
   );

   modport slave (
      input  instruction,
      output regWriteFlag, opType, memWriteFlag, memReadFlag,
      output aluControlCode, branchFlag, unconditionalBranchFlag, aluSRC
   );
endinterface

// File: rtl/processor_ctrl.sv
// ---------------------------------------------------------------------------
// processor_ctrl
//  Main control/decode unit of the ARM-LP datapath. The instruction word is
//  classified combinationally and every control flag is registered, so the
//  flags appear one clock after the instruction is presented.
//  Ports:
//    clk    in  system clock, rising edge
//    reset  in  synchronous active-high; clears every registered output
//    bus    slave side of processor_ctrl_if (instruction in, flags out)
// ---------------------------------------------------------------------------
module processor_ctrl (
   input  logic             clk,
   input  logic             reset,
   processor_ctrl_if.slave  bus
);

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_R     = 3'd1;
   localparam logic [2:0] OP_I     = 3'd2;
   localparam logic [2:0] OP_LOAD  = 3'd3;
   localparam logic [2:0] OP_STORE = 3'd4;
   localparam logic [2:0] OP_B     = 3'd5;
   localparam logic [2:0] OP_CB    = 3'd6;
   localparam logic [2:0] OP_MOV   = 3'd7;

   localparam logic [3:0] ALU_ADD  = 4'd2;
   localparam logic [3:0] ALU_SUB  = 4'd10;
   localparam logic [3:0] ALU_AND  = 4'd6;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd9;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_NAND = 4'd12;
   localparam logic [3:0] ALU_MOV  = 4'd13;
   localparam logic [3:0] ALU_PASS = 4'd7;   // CBZ tests the B operand directly
   localparam logic [3:0] ALU_NOP  = 4'd0;

   logic [31:0] instr;
   logic [3:0]  func_alu;

   logic        reg_write_d, reg_write_q;
   logic [2:0]  op_type_d,   op_type_q;
   logic        mem_write_d, mem_write_q;
   logic        mem_read_d,  mem_read_q;
   logic [3:0]  alu_ctrl_d,  alu_ctrl_q;
   logic        branch_d,    branch_q;
   logic        ubranch_d,   ubranch_q;
   logic        alu_src_d,   alu_src_q;

   assign instr = bus.instruction;

   // Function field in the top three bits selects the ALU op for R and I.
   always_comb begin
      func_alu = ALU_ADD;
      case (instr[31:29])
         3'b000:  func_alu = ALU_ADD;
         3'b001:  func_alu = ALU_SUB;
         3'b010:  func_alu = ALU_AND;
         3'b011:  func_alu = ALU_OR;
         3'b100:  func_alu = ALU_XOR;
         3'b101:  func_alu = ALU_NOR;
         3'b110:  func_alu = ALU_NAND;
         default: func_alu = ALU_MOV;
      endcase
   end

   // Class decode is a priority chain: b26 outranks b27, which outranks b28,
   // so e.g. a word with b26 and b27 set is always a branch.
   always_comb begin
      reg_write_d = 1'b0;
      op_type_d   = OP_NONE;
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;
      alu_ctrl_d  = ALU_NOP;
      branch_d    = 1'b0;
      ubranch_d   = 1'b0;
      alu_src_d   = 1'b0;

      if (instr[26] && instr[29]) begin
         op_type_d  = OP_CB;
         branch_d   = 1'b1;
         alu_ctrl_d = ALU_PASS;
      end else if (instr[26]) begin
         op_type_d  = OP_B;
         ubranch_d  = 1'b1;
      end else if (instr[27] && instr[28]) begin
         op_type_d   = OP_STORE;
         mem_write_d = 1'b1;
         alu_ctrl_d  = ALU_ADD;
         alu_src_d   = 1'b1;
      end else if (instr[27]) begin
         op_type_d   = OP_R;
         reg_write_d = 1'b1;
         alu_ctrl_d  = func_alu;
      end else if (instr[28] && instr[22]) begin
         op_type_d   = OP_LOAD;
         reg_write_d = 1'b1;
         mem_read_d  = 1'b1;
         alu_ctrl_d  = ALU_ADD;
         alu_src_d   = 1'b1;
      end else if (instr[28] && instr[23]) begin
         op_type_d   = OP_MOV;
         reg_write_d = 1'b1;
         alu_ctrl_d  = ALU_MOV;
         alu_src_d   = 1'b1;
      end else if (instr[28]) begin
         op_type_d   = OP_I;
         reg_write_d = 1'b1;
         alu_ctrl_d  = func_alu;
         alu_src_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_q <= 1'b0;
         op_type_q   <= OP_NONE;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         alu_ctrl_q  <= ALU_NOP;
         branch_q    <= 1'b0;
         ubranch_q   <= 1'b0;
         alu_src_q   <= 1'b0;
      end else begin
         reg_write_q <= reg_write_d;
         op_type_q   <= op_type_d;
         mem_write_q <= mem_write_d;
         mem_read_q  <= mem_read_d;
         alu_ctrl_q  <= alu_ctrl_d;
         branch_q    <= branch_d;
         ubranch_q   <= ubranch_d;
         alu_src_q   <= alu_src_d;
      end
   end

   assign bus.regWriteFlag            = reg_write_q;
   assign bus.opType                  = op_type_q;
   assign bus.memWriteFlag            = mem_write_q;
   assign bus.memReadFlag             = mem_read_q;
   assign bus.aluControlCode          = alu_ctrl_q;
   assign bus.branchFlag              = branch_q;
   assign bus.unconditionalBranchFlag = ubranch_q;
   assign bus.aluSRC                  = alu_src_q;

endmodule

// File: tb/tb_processor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_processor_ctrl
//  Directed and random checks of processor_ctrl against a table-driven model.
//  Outputs are compared as one packed word:
//    {regW, opType[2:0], memW, memR, alu[3:0], br, ubr, aluSRC}
// ---------------------------------------------------------------------------
module tb_processor_ctrl;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   logic [12:0] prev_exp;
   logic        prev_valid;

   processor_ctrl_if bus_if ();

   processor_ctrl u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] pack(input logic rw, input logic [2:0] op,
                                        input logic mw, input logic mr,
                                        input logic [3:0] alu, input logic br,
                                        input logic ubr, input logic src);
      return {rw, op, mw, mr, alu, br, ubr, src};
   endfunction

   // Reference: pick the class by the listed priority rules, then look the
   // flags up in a per-class table.
   function automatic logic [12:0] model(input logic [31:0] w);
      int cls;
      int f_alu [8];
      int f;
      f_alu = '{2, 10, 6, 4, 9, 5, 12, 13};
      f = int'(w[31:29]);
      if      (w[26] && w[29]) cls = 6;
      else if (w[26])          cls = 5;
      else if (w[27] && w[28]) cls = 4;
      else if (w[27])          cls = 1;
      else if (w[28] && w[22]) cls = 3;
      else if (w[28] && w[23]) cls = 7;
      else if (w[28])          cls = 2;
      else                     cls = 0;
      case (cls)
         1:       return pack(1, 3'd1, 0, 0, 4'(f_alu[f]), 0, 0, 0);
         2:       return pack(1, 3'd2, 0, 0, 4'(f_alu[f]), 0, 0, 1);
         3:       return pack(1, 3'd3, 0, 1, 4'd2,  0, 0, 1);
         4:       return pack(0, 3'd4, 1, 0, 4'd2,  0, 0, 1);
         5:       return pack(0, 3'd5, 0, 0, 4'd0,  0, 1, 0);
         6:       return pack(0, 3'd6, 0, 0, 4'd7,  1, 0, 0);
         7:       return pack(1, 3'd7, 0, 0, 4'd13, 0, 0, 1);
         default: return 13'd0;
      endcase
   endfunction

   function automatic logic [12:0] observed();
      return pack(bus_if.regWriteFlag, bus_if.opType, bus_if.memWriteFlag,
                  bus_if.memReadFlag, bus_if.aluControlCode, bus_if.branchFlag,
                  bus_if.unconditionalBranchFlag, bus_if.aluSRC);
   endfunction

   task automatic check(input string tag, input logic [12:0] exp);
      logic [12:0] obs;
      obs = observed();
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s instr=%h observed=%h expected=%h", tag,
                bus_if.instruction, obs, exp);
      end
   endtask

   // Called #1 after a rising edge. Drives new inputs, confirms outputs hold
   // their previous value until the next edge, then checks the new decode.
   task automatic step(input string tag, input logic [31:0] w, input logic r);
      logic [12:0] exp;
      bus_if.instruction = w;
      reset = r;
      exp = r ? 13'd0 : model(w);
      #2;
      if (prev_valid) check({tag, "_hold"}, prev_exp);
      @(posedge clk); #1;
      check(tag, exp);
      $display("step %-10s instr=%h reset=%0d flags=%h", tag, w, r, observed());
      prev_exp = exp;
      prev_valid = 1'b1;
   endtask

   initial begin
      logic [31:0] w;
      logic [12:0] o;
      total = 0;
      bad = 0;
      prev_valid = 1'b0;
      prev_exp = 13'd0;
      reset = 1'b1;
      bus_if.instruction = 32'h1040_0000;
      @(posedge clk); #1;

      step("rst1",    32'h1040_0000, 1'b1);
      step("rst2",    32'h2400_0000, 1'b1);
      step("rel0",    32'h0000_0000, 1'b0);
      step("load",    32'h1040_0000, 1'b0);
      step("cb",      32'h2400_0000, 1'b0);
      step("b",       32'h0400_0000, 1'b0);
      step("r_add",   32'h0800_0000, 1'b0);
      step("r_sub",   32'h2800_0000, 1'b0);
      step("r_mov",   32'hE800_0000, 1'b0);
      step("store",   32'h1800_0000, 1'b0);
      step("i_add",   32'h1000_0000, 1'b0);
      step("mov",     32'h1080_0000, 1'b0);
      step("i_nand",  32'hD000_0000, 1'b0);
      step("r_and",   32'h4800_0000, 1'b0);
      step("prio_b",  32'h1C00_0000, 1'b0);   // b26 beats store bits
      step("prio_ld", 32'h10C0_0000, 1'b0);   // b22 beats b23
      step("none",    32'hFFFF_FFFF & 32'h03BF_FFFF, 1'b0);
      step("mid_rst", 32'h1040_0000, 1'b1);
      step("after",   32'h1040_0000, 1'b0);

      for (int i = 0; i < 200; i++) begin
         w = $urandom;
         step("rand", w, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
         o = observed();
         total++;
         assert (!(o[8] && o[7])) else begin
            bad++;
            $error("FAIL memrw_excl observed=%b expected=not both", o[8:7]);
         end
         total++;
         assert (!(o[2] && o[1])) else begin
            bad++;
            $error("FAIL br_excl observed=%b expected=not both", o[2:1]);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
